// File: rtl/uart_tx_fifo_if.sv
`default_nettype none
// ============================================================================
// Module : uart_tx_fifo_if
// Push handshake and serial-line status bundle for uart_tx_fifo.
// Rev    : 1.0
// ============================================================================
interface uart_tx_fifo_if #(
  parameter int FIFO_DEPTH = 4
) ();
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]       txbyte;
  logic             tx_valid;
  logic             tx_ready;
  logic             tx;
  logic             busy;
  logic             txdone;
  logic [LVL_W-1:0] fifo_level;

  modport master (
    output txbyte,
    output tx_valid,
    input  tx_ready,
    input  tx,
    input  busy,
    input  txdone,
    input  fifo_level
  );

  modport slave (
    input  txbyte,
    input  tx_valid,
    output tx_ready,
    output tx,
    output busy,
    output txdone,
    output fifo_level
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module : uart_tx_fifo
// Buffered UART transmitter: baud generator, configurable frame, small FIFO.
// Rev    : 1.0
// ============================================================================
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 1250,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  uart_tx_fifo_if.slave tx_if
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = 3;

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] BAUD_PRE  = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);
  localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);
  localparam logic [LVL_W-1:0] LVL_EMPTY = '0;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wptr_q, wptr_d;
  logic [PTR_W-1:0]     rptr_q, rptr_d;
  logic [LVL_W-1:0]     level_q, level_d;

  state_e               state_q;
  logic [CNT_W-1:0]     baud_q;
  logic [IDX_W-1:0]     idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_q;
  logic                 tx_q;
  logic                 busy_q;
  logic                 txdone_q;

  logic                 w_push;
  logic                 w_pop;
  logic                 w_baud_last;
  logic                 w_frame_end;
  logic                 w_par;
  logic [DATA_BITS-1:0] w_wr_data;
  logic [DATA_BITS-1:0] w_rd_data;
  logic [7:0]           w_unused_txbyte;

  assign w_unused_txbyte = tx_if.txbyte;
  assign w_wr_data       = tx_if.txbyte[DATA_BITS-1:0];
  assign w_rd_data       = mem_q[rptr_q];
  assign w_par           = (PARITY == 1) ? ~(^w_rd_data) : (^w_rd_data);

  // Readiness comes from the registered level only, so a pop in the same
  // cycle never opens room for a push into a full FIFO.
  assign w_push      = tx_if.tx_valid && (level_q != LVL_FULL);
  assign w_baud_last = (baud_q == BAUD_LAST);
  assign w_frame_end = (state_q == S_STOP) && w_baud_last && (idx_q == STOP_LAST);
  assign w_pop       = (level_q != LVL_EMPTY) && ((state_q == S_IDLE) || w_frame_end);

  assign tx_if.tx_ready   = (level_q != LVL_FULL);
  assign tx_if.tx         = tx_q;
  assign tx_if.busy       = busy_q;
  assign tx_if.txdone     = txdone_q;
  assign tx_if.fifo_level = level_q;

  always_comb begin
    wptr_d  = w_push ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = w_pop  ? rptr_q + 1'b1 : rptr_q;
    level_d = level_q;
    unique case ({w_push, w_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wptr_q] <= w_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  // tx/busy/txdone are loaded with the value of the state being entered,
  // so the line changes exactly on bit boundaries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      txdone_q <= 1'b0;
    end else begin
      txdone_q <= (state_q == S_STOP) && (idx_q == STOP_LAST) && (baud_q == BAUD_PRE);
      baud_q   <= w_baud_last ? '0 : baud_q + 1'b1;
      if (w_pop) begin
        state_q <= S_START;
        shift_q <= w_rd_data;
        par_q   <= w_par;
        baud_q  <= '0;
        idx_q   <= '0;
        tx_q    <= 1'b0;
        busy_q  <= 1'b1;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            tx_q   <= 1'b1;
            busy_q <= 1'b0;
          end
          S_START: begin
            if (w_baud_last) begin
              state_q <= S_DATA;
              tx_q    <= shift_q[0];
            end
          end
          S_DATA: begin
            if (w_baud_last) begin
              shift_q <= shift_q >> 1;
              if (idx_q == DATA_LAST) begin
                idx_q <= '0;
                if (PARITY != 0) begin
                  state_q <= S_PARITY;
                  tx_q    <= par_q;
                end else begin
                  state_q <= S_STOP;
                  tx_q    <= 1'b1;
                end
              end else begin
                idx_q <= idx_q + 1'b1;
                tx_q  <= shift_q[1];
              end
            end
          end
          S_PARITY: begin
            if (w_baud_last) begin
              state_q <= S_STOP;
              tx_q    <= 1'b1;
            end
          end
          S_STOP: begin
            if (w_baud_last) begin
              if (idx_q != STOP_LAST) begin
                idx_q <= idx_q + 1'b1;
              end else begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
              end
            end
          end
          default: begin
            state_q <= S_IDLE;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module : tb_uart_tx_fifo
// Directed bench for uart_tx_fifo: 8N1 scoreboard instance plus 7E2/7O2 pair.
// Rev    : 1.0
// ============================================================================
module tb_uart_tx_fifo;
  localparam int CPB     = 4;
  localparam int FRAME_A = CPB * 10;
  localparam int FRAME_P = CPB * 11;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_fifo_if #(.FIFO_DEPTH(4)) if_a ();
  uart_tx_fifo_if #(.FIFO_DEPTH(4)) if_e ();
  uart_tx_fifo_if #(.FIFO_DEPTH(4)) if_o ();

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4))
    dut_a (.clk(clk), .rst_n(rst_n), .tx_if(if_a));
  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4))
    dut_e (.clk(clk), .rst_n(rst_n), .tx_if(if_e));
  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4))
    dut_o (.clk(clk), .rst_n(rst_n), .tx_if(if_o));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard for dut_a: bytes expected on the line, in push order.
  logic [7:0] exp_q[$];
  int         starts[$];
  int         frames_a = 0;
  bit         mon_in   = 1'b0;
  int         mon_cyc  = 0;
  logic [9:0] mon_bits;
  logic [7:0] mon_byte;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_in = 1'b0;
        chk("a_rst_tx", if_a.tx, 1);
        chk("a_rst_busy", if_a.busy, 0);
      end else begin
        if (!mon_in && if_a.tx === 1'b0) begin
          chk("a_sb_has_data", exp_q.size() > 0, 1);
          mon_byte = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
          mon_bits = {1'b1, mon_byte, 1'b0};
          mon_in   = 1'b1;
          mon_cyc  = 0;
          starts.push_back(cyc);
        end
        if (mon_in) begin
          chk("a_tx", if_a.tx, mon_bits[mon_cyc / CPB]);
          chk("a_busy", if_a.busy, 1);
          chk("a_txdone", if_a.txdone, (mon_cyc == FRAME_A - 1));
          mon_cyc++;
          if (mon_cyc == FRAME_A) begin
            mon_in = 1'b0;
            frames_a++;
          end
        end else begin
          chk("a_idle_busy", if_a.busy, 0);
          chk("a_idle_txdone", if_a.txdone, 0);
        end
      end
    end
  end

  task automatic wait_txdone(input string tag, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      seen = (if_a.txdone === 1'b1);
    end
    chk(tag, seen, 1);
  endtask

  task automatic wait_frames(input string tag, input int n, input int budget);
    for (int i = 0; i < budget && frames_a < n; i++) tick();
    chk(tag, frames_a, n);
  endtask

  logic [7:0]  b2b [5];
  logic [10:0] fe;
  logic [10:0] fo;

  initial begin
    b2b = '{8'h3C, 8'h81, 8'h7E, 8'h12, 8'hF0};
    fe  = {2'b11, 1'b0, 7'h55, 1'b0};
    fo  = {2'b11, 1'b1, 7'h55, 1'b0};
    if_a.tx_valid = 1'b0; if_a.txbyte = 8'h00;
    if_e.tx_valid = 1'b0; if_e.txbyte = 8'h00;
    if_o.tx_valid = 1'b0; if_o.txbyte = 8'h00;

    // Reset values, then a long idle stretch.
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_tx", if_a.tx, 1);
    chk("rst_ready", if_a.tx_ready, 1);
    chk("rst_level", if_a.fifo_level, 0);
    chk("rst_busy", if_a.busy, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("idle_tx", if_a.tx, 1);
    end

    // Single 8N1 frame and start latency.
    if_a.txbyte = 8'hA5; if_a.tx_valid = 1'b1;
    chk("a5_ready", if_a.tx_ready, 1);
    exp_q.push_back(8'hA5);
    tick();
    if_a.tx_valid = 1'b0;
    chk("a5_level_n1", if_a.fifo_level, 1);
    chk("a5_tx_n1", if_a.tx, 1);
    tick();
    chk("a5_tx_n2", if_a.tx, 0);
    chk("a5_busy_n2", if_a.busy, 1);
    chk("a5_level_n2", if_a.fifo_level, 0);
    wait_frames("a5_frame_timeout", 1, 100);

    // 7-bit even/odd parity, two stop bits; bit 7 of the byte is ignored.
    if_e.txbyte = 8'hD5; if_e.tx_valid = 1'b1;
    if_o.txbyte = 8'hD5; if_o.tx_valid = 1'b1;
    tick();
    if_e.tx_valid = 1'b0; if_o.tx_valid = 1'b0;
    chk("e_level_n1", if_e.fifo_level, 1);
    chk("e_tx_n1", if_e.tx, 1);
    for (int k = 0; k < FRAME_P; k++) begin
      tick();
      chk("e_tx", if_e.tx, fe[k / CPB]);
      chk("o_tx", if_o.tx, fo[k / CPB]);
      chk("e_busy", if_e.busy, 1);
      chk("e_txdone", if_e.txdone, (k == FRAME_P - 1));
      chk("o_txdone", if_o.txdone, (k == FRAME_P - 1));
    end
    tick();
    chk("e_end_busy", if_e.busy, 0);
    chk("o_end_busy", if_o.busy, 0);
    chk("e_end_tx", if_e.tx, 1);

    // Five consecutive pushes fill the FIFO; a sixth is refused.
    for (int i = 0; i < 5; i++) begin
      if_a.txbyte = b2b[i]; if_a.tx_valid = 1'b1;
      chk("b2b_ready", if_a.tx_ready, 1);
      exp_q.push_back(b2b[i]);
      tick();
    end
    if_a.txbyte = 8'hEE;
    chk("full_ready", if_a.tx_ready, 0);
    chk("full_level", if_a.fifo_level, 4);
    tick();
    chk("full_level_hold", if_a.fifo_level, 4);

    // Push held against a full FIFO across the pop cycle stays rejected.
    if_a.txbyte = 8'h99;
    wait_txdone("full_pop_timeout", 100);
    chk("full_pop_ready", if_a.tx_ready, 0);
    tick();
    if_a.tx_valid = 1'b0;
    chk("after_pop_level", if_a.fifo_level, 3);
    chk("after_pop_ready", if_a.tx_ready, 1);
    wait_txdone("lvl2_timeout", 100);
    tick();
    chk("lvl2_level", if_a.fifo_level, 2);

    // Push and pop together at level 2.
    wait_txdone("pushpop_timeout", 100);
    if_a.txbyte = 8'h5A; if_a.tx_valid = 1'b1;
    chk("pushpop_ready", if_a.tx_ready, 1);
    chk("pushpop_level_pre", if_a.fifo_level, 2);
    exp_q.push_back(8'h5A);
    tick();
    if_a.tx_valid = 1'b0;
    chk("pushpop_level", if_a.fifo_level, 2);
    wait_frames("b2b_frames_timeout", 7, 400);
    for (int k = 1; k < 6; k++) begin
      chk("b2b_gap", starts[k + 1] - starts[k], FRAME_A);
    end

    // Asynchronous reset in the middle of data bit 3.
    if_a.txbyte = 8'h96; if_a.tx_valid = 1'b1;
    exp_q.push_back(8'h96);
    tick();
    if_a.txbyte = 8'h33;
    exp_q.push_back(8'h33);
    tick();
    if_a.tx_valid = 1'b0;
    repeat (17) tick();
    chk("mid_bit3_tx", if_a.tx, 0);
    chk("mid_busy", if_a.busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tx", if_a.tx, 1);
    chk("mid_rst_busy", if_a.busy, 0);
    chk("mid_rst_level", if_a.fifo_level, 0);
    chk("mid_rst_ready", if_a.tx_ready, 1);
    exp_q.delete();
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    if_a.txbyte = 8'hC3; if_a.tx_valid = 1'b1;
    exp_q.push_back(8'hC3);
    tick();
    if_a.tx_valid = 1'b0;
    wait_frames("post_rst_frame_timeout", 8, 100);
    tick();
    chk("sb_drained", exp_q.size(), 0);
    chk("final_level", if_a.fifo_level, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
